// File: rtl/tick_scheduler.sv
// -----------------------------------------------------------------------------
// tick_scheduler
//
// Replay controller that walks the price ROM and hands one sample to the TLU
// every programmable tick period. A start/stop FSM (IDLE, WAIT_TICK, FETCH,
// ISSUE) replaces a free-running enable counter. Samples are fetched with the
// ROM's one-cycle read latency in mind. The controller holds a sample while
// the TLU deasserts ready, stops after a programmed sample count, and flags
// any tick it had to drop.
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous, active-high reset
//   start         begin a replay (only looked at in IDLE)
//   stop          abort a replay (any state, beats everything but rst)
//   tick_period   cycles per sample, latched on start, clamped to >= 3
//   num_samples   samples to replay, latched on start
//   rom_addr      registered ROM address
//   rom_dout      ROM read data (registered ROM, 1-cycle latency)
//   tlu_ready     TLU can accept a sample this cycle
//   tlu_enable    sample-issue strobe to the TLU
//   tlu_data      registered sample presented to the TLU
//   busy          high in every state except IDLE
//   done          one-cycle pulse after the final sample is accepted
//   overrun       sticky flag: a tick arrived while a sample was in flight
//   sample_count  samples accepted in the current run
// -----------------------------------------------------------------------------
module tick_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [PERIOD_WIDTH-1:0] tick_period,
  input  logic [ADDR_WIDTH-1:0]   num_samples,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [DATA_WIDTH-1:0]   rom_dout,
  input  logic                    tlu_ready,
  output logic                    tlu_enable,
  output logic [DATA_WIDTH-1:0]   tlu_data,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun,
  output logic [ADDR_WIDTH-1:0]   sample_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    FETCH     = 2'd2,
    ISSUE     = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [PERIOD_WIDTH-1:0] period_reg, period_next;
  logic [ADDR_WIDTH-1:0]   limit_reg, limit_next;
  logic [PERIOD_WIDTH-1:0] tick_cnt_reg, tick_cnt_next;
  logic [ADDR_WIDTH-1:0]   rom_addr_reg, rom_addr_next;
  logic [DATA_WIDTH-1:0]   tlu_data_reg, tlu_data_next;
  logic [ADDR_WIDTH-1:0]   sample_count_reg, sample_count_next;
  logic                    overrun_reg, overrun_next;
  logic                    done_reg, done_next;

  logic                    tick;
  logic [ADDR_WIDTH-1:0]   count_plus_one;

  // period_reg is never below 3 once a run is active, so P-1 cannot underflow
  // while the tick is qualified by a non-IDLE state.
  assign tick           = (state_reg != IDLE) &&
                          (tick_cnt_reg == period_reg - PERIOD_WIDTH'(1));
  assign count_plus_one = sample_count_reg + ADDR_WIDTH'(1);

  assign tlu_enable   = (state_reg == ISSUE) && tlu_ready && !stop;
  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;
  assign overrun      = overrun_reg;
  assign rom_addr     = rom_addr_reg;
  assign tlu_data     = tlu_data_reg;
  assign sample_count = sample_count_reg;

  always_comb begin
    state_next        = state_reg;
    period_next       = period_reg;
    limit_next        = limit_reg;
    tick_cnt_next     = tick_cnt_reg;
    rom_addr_next     = rom_addr_reg;
    tlu_data_next     = tlu_data_reg;
    sample_count_next = sample_count_reg;
    overrun_next      = overrun_reg;
    done_next         = 1'b0;

    // The tick counter free-runs through every active state so that ticks
    // stay on a fixed grid even when a sample is stalled by the TLU.
    if (state_reg != IDLE) begin
      tick_cnt_next = tick ? '0 : tick_cnt_reg + PERIOD_WIDTH'(1);
    end

    if (stop) begin
      // Abort: overrun and sample_count are left alone for inspection.
      state_next    = IDLE;
      tick_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            limit_next        = num_samples;
            period_next       = (tick_period < PERIOD_WIDTH'(3)) ?
                                PERIOD_WIDTH'(3) : tick_period;
            rom_addr_next     = '0;
            sample_count_next = '0;
            overrun_next      = 1'b0;
            tick_cnt_next     = '0;
            if (num_samples == '0) begin
              done_next = 1'b1;
            end else begin
              state_next = WAIT_TICK;
            end
          end
        end

        WAIT_TICK: begin
          if (tick) begin
            state_next = FETCH;
          end
        end

        FETCH: begin
          // rom_addr has been stable long enough that rom_dout is valid here.
          tlu_data_next = rom_dout;
          state_next    = ISSUE;
          if (tick) begin
            overrun_next = 1'b1;
          end
        end

        ISSUE: begin
          if (tick) begin
            overrun_next = 1'b1;
          end
          if (tlu_ready) begin
            rom_addr_next     = rom_addr_reg + ADDR_WIDTH'(1);
            sample_count_next = count_plus_one;
            if (count_plus_one == limit_reg) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = WAIT_TICK;
            end
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      period_reg       <= '0;
      limit_reg        <= '0;
      tick_cnt_reg     <= '0;
      rom_addr_reg     <= '0;
      tlu_data_reg     <= '0;
      sample_count_reg <= '0;
      overrun_reg      <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      period_reg       <= period_next;
      limit_reg        <= limit_next;
      tick_cnt_reg     <= tick_cnt_next;
      rom_addr_reg     <= rom_addr_next;
      tlu_data_reg     <= tlu_data_next;
      sample_count_reg <= sample_count_next;
      overrun_reg      <= overrun_next;
      done_reg         <= done_next;
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tick_scheduler
//
// Directed and randomized checks of tick_scheduler. Expected issue cycles are
// derived from the tick grid: ticks fall on multiples of the clamped period
// after start, each sample is offered two cycles after its tick, accepted on
// the first ready cycle, and the next sample waits for the first tick after
// that accept.
// -----------------------------------------------------------------------------
module tb_tick_scheduler;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [PW-1:0] tick_period;
  logic [AW-1:0] num_samples;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;
  logic          tlu_ready;
  logic          tlu_enable;
  logic [DW-1:0] tlu_data;
  logic          busy;
  logic          done;
  logic          overrun;
  logic [AW-1:0] sample_count;

  logic [DW-1:0] rom_mem [0:255];
  bit            ready_pat [0:1023];
  int            checks   = 0;
  int            failures = 0;
  int            act_c[$];

  always #5 clk = ~clk;

  // Registered ROM with one cycle of read latency.
  always @(posedge clk) rom_dout <= rom_mem[rom_addr[7:0]];

  tick_scheduler #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .PERIOD_WIDTH(PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .tick_period (tick_period),
    .num_samples (num_samples),
    .rom_addr    (rom_addr),
    .rom_dout    (rom_dout),
    .tlu_ready   (tlu_ready),
    .tlu_enable  (tlu_enable),
    .tlu_data    (tlu_data),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .sample_count(sample_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_ready(input bit val);
    for (int i = 0; i < 1024; i++) ready_pat[i] = val;
  endtask

  // One replay. rel counts cycles from the start cycle (rel 0). stop_rel,
  // rst_rel and restart_rel are -1 when unused.
  task automatic run(input int p, input int n, input int stop_rel, input int rst_rel,
                     input int restart_rel, input string name);
    int pe, t, c, end_rel, done_rel, busy_end, k, rel;
    int exp_c[$];
    int exp_t[$];
    bit exp_ov, fin, is_rst;
    pe      = (p < 3) ? 3 : p;
    t       = pe;
    exp_ov  = 1'b0;
    is_rst  = (rst_rel >= 0);
    end_rel = (stop_rel >= 0) ? stop_rel : rst_rel;
    for (int i = 0; i < n; i++) begin
      c = t + 2;
      while (c < 1023 && !ready_pat[c]) c++;
      if (end_rel >= 0 && c >= end_rel) break;
      if (t + pe <= c) exp_ov = 1'b1;
      exp_t.push_back(t);
      exp_c.push_back(c);
      t = (c / pe + 1) * pe;
    end
    if (end_rel >= 0) begin
      done_rel = -1;
      busy_end = end_rel + 1;
    end else begin
      done_rel = (n == 0) ? 1 : exp_c[n-1] + 1;
      busy_end = done_rel;
    end

    act_c.delete();
    k   = 0;
    rel = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      start       = (rel == 0) || (rel == restart_rel);
      tick_period = (rel == 0) ? PW'(p) : PW'($urandom_range(0, 2));
      num_samples = (rel == 0) ? AW'(n) : AW'(1);
      stop        = (rel == stop_rel);
      rst         = (rel == rst_rel);
      tlu_ready   = ready_pat[rel];
      #1;
      if (rel >= 1) begin
        check({name, " busy"}, busy, (rel < busy_end));
        check({name, " done"}, done, (rel == done_rel));
        if (tlu_enable) begin
          act_c.push_back(rel);
          if (k < exp_c.size()) begin
            check({name, " enable_cycle"}, rel, exp_c[k]);
            check({name, " enable_data"}, tlu_data, rom_mem[k]);
          end else begin
            check({name, " unexpected_enable"}, tlu_enable, 0);
          end
          k++;
        end
        for (int i = 0; i < exp_c.size(); i++) begin
          if (rel >= exp_t[i] + 2 && rel < exp_c[i]) begin
            check({name, " stall_data"}, tlu_data, rom_mem[i]);
            check({name, " stall_enable"}, tlu_enable, 0);
          end
        end
      end
      rel++;
      if (end_rel >= 0) fin = (rel > end_rel + 3);
      else              fin = (rel > done_rel + 2);
      if (rel >= 1000) fin = 1'b1;
    end
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b0;
    check({name, " enable_count"}, k, exp_c.size());
    check({name, " sample_count"}, sample_count, is_rst ? 0 : exp_c.size());
    check({name, " overrun"}, overrun, is_rst ? 0 : exp_ov);
    check({name, " rom_addr"}, rom_addr, is_rst ? 0 : exp_c.size());
    if (is_rst) check({name, " tlu_data_reset"}, tlu_data, 0);
    $display("run %s P=%0d N=%0d enables=%0d overrun=%0d", name, p, n, k, overrun);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    tlu_ready   = 1'b1;
    tick_period = '0;
    num_samples = '0;
    for (int i = 0; i < 256; i++) rom_mem[i] = DW'(i * 7 + 3);
    repeat (3) @(negedge clk);
    #1;
    check("reset rom_addr", rom_addr, 0);
    check("reset tlu_data", tlu_data, 0);
    check("reset sample_count", sample_count, 0);
    check("reset tlu_enable", tlu_enable, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset overrun", overrun, 0);
    $display("reset checked");
    rst = 1'b0;

    // Basic replay with a long period.
    rom_mem[0] = 8'd10; rom_mem[1] = 8'd20; rom_mem[2] = 8'd30; rom_mem[3] = 8'd40;
    fill_ready(1'b1);
    run(60, 4, -1, -1, -1, "p60");
    check("p60 n_enables", act_c.size(), 4);
    check("p60 first_enable", act_c[0], 62);
    check("p60 last_enable", act_c[3], 242);

    // Stall at the first ISSUE long enough to drop a tick.
    fill_ready(1'b1);
    for (int i = 7; i < 14; i++) ready_pat[i] = 1'b0;
    run(5, 3, -1, -1, -1, "stall");
    check("stall overrun_set", overrun, 1);

    // Period clamp.
    fill_ready(1'b1);
    run(1, 2, -1, -1, -1, "clamp");
    check("clamp first_enable", act_c[0], 5);
    check("clamp spacing", act_c[1] - act_c[0], 3);

    // Zero-length run.
    run(3, 0, -1, -1, -1, "zero");

    // Stop in the ISSUE cycle of the third sample, then replay from 0.
    run(4, 10, 14, -1, -1, "stop");
    run(3, 2, -1, -1, -1, "after_stop");

    // start while busy is ignored; reset during WAIT_TICK.
    run(6, 2, -1, -1, 3, "restart");
    run(10, 3, -1, 15, -1, "rst_mid");

    // start and stop together in IDLE.
    @(negedge clk);
    start = 1'b1; stop = 1'b1; tick_period = PW'(3); num_samples = AW'(2);
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    #1;
    check("start_stop busy", busy, 0);
    check("start_stop done", done, 0);
    $display("start+stop in IDLE checked");

    // Randomized replays with random ready patterns and ROM contents.
    for (int r = 0; r < 10; r++) begin
      int p, n;
      p = $urandom_range(0, 9);
      n = $urandom_range(0, 6);
      for (int i = 0; i < 256; i++) rom_mem[i] = DW'($urandom_range(0, 255));
      for (int i = 0; i < 1024; i++) ready_pat[i] = ($urandom_range(0, 3) != 0);
      run(p, n, -1, -1, -1, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Replay controller that sequences market-data samples from the price ROM into the TLU. It replaces the fixed free-running enable counter with a start/stop FSM, a programmable tick period, ROM-latency-aware fetch, TLU ready backpressure, sample-count termination and overrun detection. It sits between the ROM (`rom_addr`/`dout`) and the TLU (`enable`/`data_in`) inside the top level.

## Interface
- `DATA_WIDTH`, 8, sample width
- `ADDR_WIDTH`, 16, ROM address width; also the sample-count width
- `PERIOD_WIDTH`, 16, tick-period register width
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  begin replay; sampled only in IDLE
- `stop`  in  1  abort replay; effective in any state
- `tick_period`  in  PERIOD_WIDTH  cycles per sample; latched on start
- `num_samples`  in  ADDR_WIDTH  samples to replay; latched on start
- `rom_addr`  out  ADDR_WIDTH  ROM address, registered
- `rom_dout`  in  DATA_WIDTH  ROM data; registered ROM, 1-cycle latency
- `tlu_ready`  in  1  TLU can accept a sample this cycle
- `tlu_enable`  out  1  sample-issue strobe to the TLU
- `tlu_data`  out  DATA_WIDTH  sample to the TLU, registered
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last sample is issued
- `overrun`  out  1  sticky: a tick was dropped
- `sample_count`  out  ADDR_WIDTH  samples issued in the current run

## Operation
- Reset values:
  - state IDLE
  - `rom_addr` 0, `tlu_data` 0, `sample_count` 0
  - `tlu_enable` 0, `busy` 0, `done` 0, `overrun` 0
  - internal tick counter 0
- States: IDLE, WAIT_TICK, FETCH, ISSUE.
- IDLE + `start`:
  - latch `num_samples`
  - latch `tick_period` clamped to at least 3 (values 0, 1, 2 become 3)
  - clear `rom_addr`, `sample_count`, `overrun` and the tick counter
  - if latched count is 0: pulse `done` next cycle and stay IDLE
  - otherwise go to WAIT_TICK
- Tick counter:
  - runs in every non-IDLE state, counting 0..P-1 and wrapping
  - tick = counter equals P-1
- WAIT_TICK + tick: go to FETCH.
- FETCH (exactly one cycle): capture `rom_dout` into `tlu_data`, then go to ISSUE.
- ISSUE:
  - `tlu_enable` = ISSUE & `tlu_ready` & !`stop` (combinational from registered state)
  - on an accepted cycle: `rom_addr`+1, `sample_count`+1
  - if `sample_count`+1 equals the latched count: go to IDLE and pulse `done` the next cycle
  - otherwise go to WAIT_TICK
  - if `tlu_ready` is low, hold ISSUE with `tlu_data` stable
- A tick arriving in FETCH or ISSUE, or in the ISSUE accept cycle, is dropped and sets `overrun`. The counter keeps running and the next tick comes P cycles later.
- `stop` (priority over everything except `rst`):
  - next state IDLE
  - no `done` pulse
  - `tlu_enable` is 0 in the stop cycle
  - `overrun` and `sample_count` hold for inspection until the next `start`
- `start` while busy is ignored. `start` and `stop` together in IDLE: `stop` wins and the block stays IDLE.
- `rom_addr` wraps modulo 2^ADDR_WIDTH. The count limit is `num_samples`, so no wrap occurs within a run.
- `rst` mid-run returns all outputs to reset values on the next edge. No `done` pulse.

## Timing
- `start` sampled at cycle S: WAIT_TICK with counter 0 at S+1.
- First tick at S+P. FETCH at S+P+1. Earliest `tlu_enable` at S+P+2.
- Tick-to-enable latency is 2 cycles plus any `tlu_ready` stall cycles.
- With no stall, enables are exactly P cycles apart.
- `rom_addr` changes on the edge after an accept. It is stable at least 2 cycles before the next FETCH, which the P >= 3 clamp guarantees.
- `done` is asserted the cycle after the final accept and lasts 1 cycle. `busy` falls in that same cycle.

## Test plan
- Reset, then `start` with P=60, N=4, ROM[0..3]=10,20,30,40, `tlu_ready`=1:
  - `tlu_enable` at S+62, S+122, S+182, S+242 carrying 10, 20, 30, 40
  - `done` at S+243, `sample_count`=4, `overrun`=0
- P=5, N=3, `tlu_ready` held low for 7 cycles at the first ISSUE:
  - first sample is held stable, then issued
  - one tick is dropped and `overrun` becomes 1
  - the remaining samples are issued after later ticks
- `tick_period`=1, N=2: behaves as P=3; enables exactly 3 cycles apart.
- N=0 `start`: `done` pulse at S+1, `busy` never asserted, no `tlu_enable`.
- P=4, N=10, `stop` asserted in the ISSUE cycle of sample 3:
  - `tlu_enable` is 0 that cycle
  - IDLE next cycle, no `done`, `sample_count`=2
  - a fresh `start` replays from address 0
- `rst` pulsed mid-WAIT_TICK: all outputs return to reset values; `start` during `busy` is ignored.
